// File: rtl/seq_subtractor_if.sv
// rtl/seq_subtractor_if.sv - operand/result handshake bundle for seq_subtractor (ovf under SEQ_SUB_OVF_EN)
interface seq_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SEQ_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
`ifdef SEQ_SUB_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
`ifdef SEQ_SUB_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/seq_subtractor.sv
// rtl/seq_subtractor.sv - digit-serial a - b - bin, DIGIT bits per cycle; SEQ_SUB_OVF_EN adds signed overflow flag
module seq_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_subtractor_if.slave    bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             bout_q;
    logic             in_ready_q;
    logic             out_valid_q;
`ifdef SEQ_SUB_OVF_EN
    logic             ovf_q;
`endif

    logic [IW-1:0]    base;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d_dig;
    logic [DIGIT:0]   chain;
    logic             last;

    // Ripple borrow through the current digit, seeded by the borrow carried from the previous one.
    always_comb begin
        base     = IW'(int'(cnt) * DIGIT);
        a_dig    = a_q[base +: DIGIT];
        b_dig    = b_q[base +: DIGIT];
        chain    = '0;
        d_dig    = '0;
        chain[0] = borrow_q;
        for (int i = 0; i < DIGIT; i++) begin
            d_dig[i]   = a_dig[i] ^ b_dig[i] ^ chain[i];
            chain[i+1] = (~a_dig[i] & b_dig[i]) | (~(a_dig[i] ^ b_dig[i]) & chain[i]);
        end
        last = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        borrow_q   <= bus.bin;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    diff_q[base +: DIGIT] <= d_dig;
                    borrow_q              <= chain[DIGIT];
                    cnt                   <= cnt + 1'b1;
                    if (last) begin
                        bout_q      <= chain[DIGIT];
`ifdef SEQ_SUB_OVF_EN
                        // The top digit is being written this cycle, so its MSB is the result sign.
                        ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &
                                       (d_dig[DIGIT-1] != a_q[WIDTH-1]);
`endif
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
`ifdef SEQ_SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_seq_subtractor.sv
// tb/tb_seq_subtractor.sv - randomized self-checking bench for seq_subtractor (WIDTH=8, DIGIT=4)
module tb_seq_subtractor;
    localparam int W = 8;
    localparam int D = 4;
    localparam int N = W / D;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    seq_subtractor_if #(.WIDTH(W)) bus ();

    seq_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        return W'(r + 256);
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return int'(x) < int'(y) + int'(c);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int r;
        r = int'($signed(x)) - int'($signed(y)) - int'(c);
        return (r > 127) || (r < -128);
    endfunction

    // Waits (bounded) for out_valid; returns edges counted after the accept edge.
    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid) break;
        end
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                         input int hold, input string tag);
        int n;
        int lat;
        logic [W-1:0] ed;
        ed = ref_diff(ta, tb_v, tbin);
        bus.a = ta; bus.b = tb_v; bus.bin = tbin; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 40) begin @(posedge clk); #1; n++; end
        chk({tag, "_acc_timeout"}, 32'(n < 40), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
        chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        wait_result(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(N));
        chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bus.bout), 32'(ref_bout(ta, tb_v, tbin)));
`ifdef SEQ_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(ref_ovf(ta, tb_v, tbin)));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_v"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_d"}, 32'(bus.diff), 32'(ed));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_xfer_v"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_xfer_r"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_kept_d"}, 32'(bus.diff), 32'(ed));
    endtask

    initial begin
        int lat;
        int seen;
        total = 0; bad = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'h35, 8'h12, 1'b0, 0, "basic");
        do_op(8'h00, 8'h01, 1'b0, 0, "wrap");
        do_op(8'h80, 8'h80, 1'b1, 1, "binwrap");
        do_op(8'h80, 8'h01, 1'b0, 0, "ovf1");
        do_op(8'h05, 8'h03, 1'b0, 0, "ovf0");

        // Asynchronous reset mid-simulation: outputs must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'h00);
        chk("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SEQ_SUB_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Backpressure with a new request pending throughout.
        bus.a = 8'h35; bus.b = 8'h12; bus.bin = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.a = 8'h77; bus.b = 8'h22;
        wait_result(lat);
        chk("bp_lat", 32'(lat), 32'(N));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_diff", 32'(bus.diff), 32'h23);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_xfer", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_acc2", 32'(bus.in_ready), 32'd0);
        wait_result(lat);
        chk("bp2_lat", 32'(lat), 32'(N));
        chk("bp2_diff", 32'(bus.diff), 32'h55);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset pulse during the first RUN cycle discards the operation.
        bus.a = 8'hAA; bus.b = 8'h0B; bus.bin = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        do_op(8'h10, 8'h01, 1'b0, 0, "after_rst");

        for (int k = 0; k < 40; k++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_subtractor.md
# seq_subtractor

- Parametrised multi-cycle subtractor computing `diff = a - b - bin` over WIDTH bits.
- Processes DIGIT bits per clock, carrying the borrow between cycles in a register.
- Intended as the area-lean arithmetic slice for datapaths that can tolerate WIDTH/DIGIT cycles of latency.
- Operand and result transfers use valid/ready handshakes.

## Interface

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  reset, asynchronous assert, active-low; all state returns to reset values immediately.
- in_valid  input  1  operands a, b and bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  difference, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned).
- ovf  output  1  signed overflow flag; present only with SEQ_SUB_OVF_EN.

## Operation

- The FSM has three states: IDLE, RUN and DONE. There are N = WIDTH/DIGIT RUN cycles.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready, register a, b and bin; clear the digit counter; go to RUN.
- RUN:
  - Each cycle computes digit i (bits i·DIGIT .. i·DIGIT+DIGIT−1) as `a_i − b_i − borrow_reg`.
  - Write the digit result into the diff register.
  - Update borrow_reg to the borrow out of that digit.
  - Borrow chain per bit matches the full-subtractor equations:
    - `d = x ^ y ^ c`
    - `c' = (~x & y) | (~(x ^ y) & c)`
  - On the cycle that processes digit N−1, latch bout = final borrow and go to DONE.
- DONE:
  - out_valid = 1; diff and bout are held stable.
  - When out_ready = 1, go to IDLE.
- in_ready is 0 in RUN and DONE. in_valid asserted in those states is ignored, and operands must be held by the producer.
- Registered a and b are not modified during RUN; inputs a, b and bin may change freely after the accept edge.
- diff and bout keep their last values after leaving DONE until the next result overwrites them.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - diff = 0, bout = 0, ovf = 0.
  - Digit counter = 0, borrow_reg = 0.
- Reset mid-operation: the in-flight operation is discarded, no out_valid pulse is produced, and the block is back in IDLE on the first edge after rst_n deasserts.
- Degenerate DIGIT = WIDTH: N = 1, giving a single RUN cycle.

## Timing

- Accept edge T0, when in_valid & in_ready are sampled high.
- RUN occupies edges T1..TN; out_valid rises after edge TN.
- Latency from the accept edge to out_valid is N cycles.
- With out_ready held high, the result transfers at edge TN+1 and in_ready is high again after TN+1. The next accept can occur at TN+2.
- Minimum initiation interval is N+2 cycles.
- Backpressure: out_valid stays high and diff, bout and ovf stay stable for any number of cycles until out_ready is high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration

- SEQ_SUB_OVF_EN defined:
  - The ovf port exists.
  - ovf is registered in DONE together with bout as `(a[W−1] != b[W−1]) & (diff[W−1] != a[W−1])`, i.e. two's-complement overflow of a − b − bin.
  - ovf is held with diff and is 0 at reset.
- SEQ_SUB_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour and timing are identical.

## Test plan

All scenarios use WIDTH = 8, DIGIT = 4 (N = 2).
- Reset then idle:
  - Stimulus: assert rst_n = 0 mid-simulation.
  - Required: in_ready = 1, out_valid = 0, diff = 0x00, bout = 0 immediately (asynchronous), with no clock edge needed.
- Basic:
  - Stimulus: a = 0x35, b = 0x12, bin = 0.
  - Required: diff = 0x23, bout = 0, out_valid 2 cycles after the accept edge.
- Inter-digit borrow and wrap:
  - Stimulus: a = 0x00, b = 0x01, bin = 0.
  - Required: diff = 0xFF, bout = 1.
  - Stimulus: a = 0x80, b = 0x80, bin = 1.
  - Required: diff = 0xFF, bout = 1.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles after out_valid, with in_valid = 1 carrying new operands throughout.
  - Required: in_ready stays 0, diff is stable, and the new operands are accepted only after the result transfers.
- Reset mid-RUN:
  - Stimulus: pulse rst_n low during the first RUN cycle.
  - Required: no out_valid; the next operation a = 0x10, b = 0x01 yields 0x0F, bout = 0.
- With SEQ_SUB_OVF_EN:
  - Stimulus: a = 0x80, b = 0x01, bin = 0.
  - Required: diff = 0x7F, bout = 0, ovf = 1.
  - Stimulus: a = 0x05, b = 0x03.
  - Required: ovf = 0.
